// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined register file and its busy scoreboard.
// Defaults, the hardwired-zero register index and the pending-counter width helper.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    // One extra bit over log2 so the counter can hold every busy register.
    function automatic int cnt_w_f(input int num_regs);
        return $clog2(num_regs) + 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits plus a running count of busy registers.
// Updates land one edge after set/clear; busy reads are state-only (no same-cycle forwarding).
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = cnt_w_f(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_vld_i,
    input  logic [ADDR_W-1:0] clr_reg_i,
    input  logic              set_vld_i,
    input  logic [ADDR_W-1:0] set_reg_i,
    input  logic [ADDR_W-1:0] rd_reg1_i,
    input  logic [ADDR_W-1:0] rd_reg2_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic [CNT_W-1:0]  pending_cnt_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                set_hit, clr_hit;
    logic                cnt_inc, cnt_dec;

    assign set_hit = set_vld_i && (set_reg_i != ADDR_W'(ZERO_REG));
    assign clr_hit = clr_vld_i && (clr_reg_i != ADDR_W'(ZERO_REG));

    // A retiring producer and a newly issued one on the same register cancel out.
    assign cnt_inc = set_hit && !busy_q[set_reg_i];
    assign cnt_dec = clr_hit && busy_q[clr_reg_i] && !(set_hit && (set_reg_i == clr_reg_i));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (clr_hit) begin
            busy_d[clr_reg_i] = 1'b0;
        end
        if (set_hit) begin
            busy_d[set_reg_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
        if (cnt_inc && !cnt_dec && (cnt_q != CNT_W'(NUM_REGS - 1))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy1_o       = busy_q[rd_reg1_i];
    assign busy2_o       = busy_q[rd_reg2_i];
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read/one-write register file, r0 hardwired to zero, optional write-to-read bypass.
// Reads are combinational; writes and busy updates appear one edge later; no backpressure.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = cnt_w_f(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Rr1,
    input  logic [ADDR_W-1:0] Rr2,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    output logic              busy1,
    output logic              busy2,
    output logic [CNT_W-1:0]  pendingCount
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_dat  [2];

    assign wr_en = regWrite && (WriteRegister != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[WriteRegister] <= WriteData;
        end
    end

    assign rd_addr[0] = Rr1;
    assign rd_addr[1] = Rr2;

    // Reads are forced to zero during reset so a bypassed write cannot leak through.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = '0;
            if (!rst_n || (rd_addr[p] == ADDR_W'(ZERO_REG))) begin
                rd_dat[p] = '0;
            end else if ((BYPASS != 0) && wr_en && (WriteRegister == rd_addr[p])) begin
                rd_dat[p] = WriteData;
            end else begin
                rd_dat[p] = mem_q[rd_addr[p]];
            end
        end
    end

    assign Rd1 = rd_dat[0];
    assign Rd2 = rd_dat[1];

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_vld_i     (regWrite),
        .clr_reg_i     (WriteRegister),
        .set_vld_i     (issueValid),
        .set_reg_i     (issueReg),
        .rd_reg1_i     (Rr1),
        .rd_reg2_i     (Rr2),
        .busy1_o       (busy1),
        .busy2_o       (busy2),
        .pending_cnt_o (pendingCount)
    );

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench: one bypassing and one non-bypassing instance driven with shared stimulus.
module tb_scoreboard_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rr1, Rr2, WriteRegister, issueReg;
    logic        regWrite, issueValid;
    logic [31:0] WriteData;

    logic [31:0] Rd1, Rd2, nb_Rd1, nb_Rd2;
    logic        busy1, busy2, nb_busy1, nb_busy2;
    logic [5:0]  pendingCount, nb_pendingCount;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    scoreboard_regfile #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .Rr1(Rr1), .Rr2(Rr2), .Rd1(Rd1), .Rd2(Rd2),
        .regWrite(regWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .issueValid(issueValid), .issueReg(issueReg),
        .busy1(busy1), .busy2(busy2), .pendingCount(pendingCount)
    );

    scoreboard_regfile #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .Rr1(Rr1), .Rr2(Rr2), .Rd1(nb_Rd1), .Rd2(nb_Rd2),
        .regWrite(regWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .issueValid(issueValid), .issueReg(issueReg),
        .busy1(nb_busy1), .busy2(nb_busy2), .pendingCount(nb_pendingCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL no_expectation: observed %0h required <queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        regWrite      = 1'b1;
        WriteRegister = r;
        WriteData     = d;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; Rr1 = 5'd3; Rr2 = 5'd0; regWrite = 1'b0; WriteRegister = '0;
        WriteData = '0; issueValid = 1'b0; issueReg = '0;

        #2;
        expect_val("reset_rd1", 32'h0);    check(Rd1);
        expect_val("reset_busy1", 32'h0);  check(32'(busy1));
        expect_val("reset_count", 32'h0);  check(32'(pendingCount));

        @(negedge clk) rst_n = 1'b1;
        tick();

        // Bypass vs stored-value read of a same-cycle write
        regWrite = 1'b1; WriteRegister = 5'd2; WriteData = 32'd3; Rr2 = 5'd2;
        #1;
        expect_val("bypass_pre", 32'd3);     check(Rd2);
        expect_val("nobypass_pre", 32'd0);   check(nb_Rd2);
        tick();
        regWrite = 1'b0;
        #1;
        expect_val("nobypass_post", 32'd3);  check(nb_Rd2);
        expect_val("bypass_post", 32'd3);    check(Rd2);

        // Writes and issues to r0 are dropped
        regWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hDEAD;
        issueValid = 1'b1; issueReg = 5'd0; Rr1 = 5'd0;
        #1;
        expect_val("r0_pre", 32'h0);          check(Rd1);
        tick();
        regWrite = 1'b0; issueValid = 1'b0;
        #1;
        expect_val("r0_post", 32'h0);         check(Rd1);
        expect_val("r0_post_nb", 32'h0);      check(nb_Rd1);
        expect_val("r0_busy", 32'h0);         check(32'(busy1));
        expect_val("r0_count", 32'h0);        check(32'(pendingCount));

        // Basic write/read sequence
        wr(5'd1, 32'd2);
        wr(5'd2, 32'd3);
        regWrite = 1'b0; WriteRegister = 5'd9; WriteData = 32'd5;
        tick();
        wr(5'd3, 32'hF);
        wr(5'd1, 32'hB);
        regWrite = 1'b0;
        Rr1 = 5'd1; Rr2 = 5'd3;
        #1;
        expect_val("basic_rd1", 32'hB);       check(Rd1);
        expect_val("basic_rd2", 32'hF);       check(Rd2);
        expect_val("basic_rd1_nb", 32'hB);    check(nb_Rd1);
        Rr1 = 5'd9;
        #1;
        expect_val("r9_ignored", 32'h0);      check(Rd1);

        // Scoreboard set/clear
        Rr1 = 5'd5; issueValid = 1'b1; issueReg = 5'd5;
        #1;
        expect_val("issue_no_fwd", 32'h0);    check(32'(busy1));
        tick();
        issueValid = 1'b0;
        #1;
        expect_val("issue_busy", 32'h1);      check(32'(busy1));
        expect_val("issue_count", 32'd1);     check(32'(pendingCount));
        issueValid = 1'b1;
        tick();
        issueValid = 1'b0;
        #1;
        expect_val("reissue_count", 32'd1);   check(32'(pendingCount));
        wr(5'd5, 32'd1);
        regWrite = 1'b0;
        #1;
        expect_val("retire_busy", 32'h0);     check(32'(busy1));
        expect_val("retire_count", 32'd0);    check(32'(pendingCount));
        wr(5'd7, 32'd7);
        regWrite = 1'b0;
        #1;
        expect_val("clear_idle_count", 32'd0); check(32'(pendingCount));

        // Simultaneous set and clear
        issueValid = 1'b1; issueReg = 5'd4;
        tick();
        issueValid = 1'b0;
        #1;
        expect_val("r4_count", 32'd1);        check(32'(pendingCount));
        issueValid = 1'b1; issueReg = 5'd4;
        regWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'd44;
        tick();
        Rr1 = 5'd4;
        issueReg = 5'd6;
        #1;
        expect_val("same_busy", 32'h1);       check(32'(busy1));
        expect_val("same_count", 32'd1);      check(32'(pendingCount));
        tick();
        issueValid = 1'b0; regWrite = 1'b0; Rr2 = 5'd6;
        #1;
        expect_val("diff_count", 32'd1);      check(32'(pendingCount));
        expect_val("diff_busy4", 32'h0);      check(32'(busy1));
        expect_val("diff_busy6", 32'h1);      check(32'(busy2));
        issueValid = 1'b1; issueReg = 5'd8;
        tick();
        issueValid = 1'b0;
        #1;
        expect_val("two_busy_count", 32'd2);  check(32'(pendingCount));

        // Mid-run reset with r3 = 0xF stored and activity pending
        Rr1 = 5'd3;
        regWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h77;
        issueValid = 1'b1; issueReg = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        expect_val("midrst_rd1", 32'h0);      check(Rd1);
        expect_val("midrst_rd1_nb", 32'h0);   check(nb_Rd1);
        expect_val("midrst_count", 32'd0);    check(32'(pendingCount));
        expect_val("midrst_busy6", 32'h0);    check(32'(busy2));
        tick();
        @(negedge clk);
        rst_n = 1'b1; regWrite = 1'b0; issueValid = 1'b0;
        #1;
        expect_val("postrst_rd1", 32'h0);     check(Rd1);
        Rr1 = 5'd9;
        #1;
        expect_val("postrst_busy9", 32'h0);   check(32'(busy1));
        expect_val("postrst_count", 32'd0);   check(32'(pendingCount));

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL leftover_expectations: observed %0d required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
